// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcode constants, operand-select encodings and immediate formats.
// Revision: 1.0
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [2:0] OP1_RS1  = 3'd0;
  localparam logic [2:0] OP1_PC   = 3'd1;
  localparam logic [2:0] OP1_ZERO = 3'd2;

  localparam logic [2:0] OP2_RS2  = 3'd0;
  localparam logic [2:0] OP2_IMM  = 3'd1;
  localparam logic [2:0] OP2_FOUR = 3'd2;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // True when a nonzero destination feeds one of the sources actually read.
  function automatic logic src_hits(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic use_rs1,
                                    input logic use_rs2);
    return (rd != 5'd0) && ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: combinational RV32I immediate generator, sign-extended to XLEN.
// Revision: 1.0
`default_nettype none

module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  imm_fmt_e          fmt,
  input  logic [31:7]       instr,
  output logic [XLEN-1:0]   imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(signed'(imm32));

endmodule

`default_nettype wire

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32I decode with ID/EX register, load-use bubble and flush.
// Revision: 1.0 -- optional illegal-instruction flag under DECODE_ILLEGAL_TRAP_EN.
`default_nettype none

module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        func3_o,
  output logic [6:0]        func7_o,
  output logic [6:0]        opcode_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              reg_wr_en_o,
  output logic              mem_wr_en_o,
  output logic              mem_rd_en_o,
  output logic [2:0]        op1_sel_o,
  output logic [2:0]        op2_sel_o
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_o
`endif
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] func7;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign func7  = instr_i[31:25];

  imm_fmt_e        fmt;
  logic            dec_reg_wr;
  logic            dec_mem_rd;
  logic            dec_mem_wr;
  logic [2:0]      dec_op1;
  logic [2:0]      dec_op2;
  logic            use_rs1;
  logic            use_rs2;
  logic [XLEN-1:0] imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            known;
  logic            dec_illegal;
`endif

  always_comb begin
    fmt        = IMM_NONE;
    dec_reg_wr = 1'b0;
    dec_mem_rd = 1'b0;
    dec_mem_wr = 1'b0;
    dec_op1    = OP1_RS1;
    dec_op2    = OP2_RS2;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    known       = 1'b1;
    dec_illegal = 1'b0;
`endif
    case (opcode)
      OPC_OP: begin
        dec_reg_wr = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt        = IMM_I;
        dec_reg_wr = 1'b1;
        dec_op2    = OP2_IMM;
        use_rs1    = 1'b1;
      end
      OPC_LOAD: begin
        fmt        = IMM_I;
        dec_reg_wr = 1'b1;
        dec_mem_rd = 1'b1;
        dec_op2    = OP2_IMM;
        use_rs1    = 1'b1;
      end
      OPC_STORE: begin
        fmt        = IMM_S;
        dec_mem_wr = 1'b1;
        dec_op2    = OP2_IMM;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_BRANCH: begin
        fmt     = IMM_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        fmt        = IMM_J;
        dec_reg_wr = 1'b1;
        dec_op1    = OP1_PC;
        dec_op2    = OP2_FOUR;
      end
      OPC_JALR: begin
        fmt        = IMM_I;
        dec_reg_wr = 1'b1;
        dec_op1    = OP1_PC;
        dec_op2    = OP2_FOUR;
        use_rs1    = 1'b1;
      end
      OPC_LUI: begin
        fmt        = IMM_U;
        dec_reg_wr = 1'b1;
        dec_op1    = OP1_ZERO;
        dec_op2    = OP2_IMM;
      end
      OPC_AUIPC: begin
        fmt        = IMM_U;
        dec_reg_wr = 1'b1;
        dec_op1    = OP1_PC;
        dec_op2    = OP2_IMM;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        known = 1'b0;
`endif
      end
    endcase

    if (rd == 5'd0) dec_reg_wr = 1'b0;

`ifdef DECODE_ILLEGAL_TRAP_EN
    dec_illegal = !known ||
                  ((opcode == OPC_OP) && (func7 != 7'h00) && (func7 != 7'h20));
    if (dec_illegal) begin
      dec_reg_wr = 1'b0;
      dec_mem_wr = 1'b0;
    end
`endif
  end

  riscv_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .fmt   (fmt),
    .instr (instr_i[31:7]),
    .imm   (imm)
  );

  logic       ld_valid_q;
  logic [4:0] ld_rd_q;
  logic       out_hazard;
  logic       shadow_hazard;
  logic       hazard;
  logic       accept;
  logic       handoff;

  assign out_hazard    = out_valid_o && mem_rd_en_o &&
                         src_hits(rd_o, rs1, rs2, use_rs1, use_rs2);
  assign shadow_hazard = ld_valid_q && src_hits(ld_rd_q, rs1, rs2, use_rs1, use_rs2);
  assign hazard        = out_hazard || shadow_hazard;
  assign in_ready_o    = (!out_valid_o || out_ready_i) && !hazard;
  assign accept        = in_valid_i && in_ready_o && !flush_i;
  assign handoff       = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      pc_o        <= '0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      rd_o        <= '0;
      func3_o     <= '0;
      func7_o     <= '0;
      opcode_o    <= '0;
      imm_o       <= '0;
      reg_wr_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      mem_rd_en_o <= 1'b0;
      op1_sel_o   <= '0;
      op2_sel_o   <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      pc_o        <= pc_i;
      rs1_o       <= rs1;
      rs2_o       <= rs2;
      rd_o        <= rd;
      func3_o     <= instr_i[14:12];
      func7_o     <= func7;
      opcode_o    <= opcode;
      imm_o       <= imm;
      reg_wr_en_o <= dec_reg_wr;
      mem_wr_en_o <= dec_mem_wr;
      mem_rd_en_o <= dec_mem_rd;
      op1_sel_o   <= dec_op1;
      op2_sel_o   <= dec_op2;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // The shadow only arms when the output-register check has not already
  // produced the bubble, so a back-to-back load-use pair costs one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
    end else if (flush_i) begin
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
    end else begin
      ld_valid_q <= handoff && mem_rd_en_o && (rd_o != 5'd0) && !out_hazard;
      ld_rd_q    <= rd_o;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      illegal_o <= 1'b0;
    end else if (!flush_i && accept) begin
      illegal_o <= dec_illegal;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: table-driven decode vectors plus handshake/hazard/flush sequences.
`default_nettype none

module tb_riscv_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  func3_q;
  logic [6:0]  func7_q, opcode_q;
  logic [31:0] imm_q;
  logic        reg_wr, mem_wr, mem_rd;
  logic [2:0]  op1_sel, op2_sel;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  riscv_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .instr_i     (instr),
    .pc_i        (pc),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .pc_o        (pc_q),
    .rs1_o       (rs1_q),
    .rs2_o       (rs2_q),
    .rd_o        (rd_q),
    .func3_o     (func3_q),
    .func7_o     (func7_q),
    .opcode_o    (opcode_q),
    .imm_o       (imm_q),
    .reg_wr_en_o (reg_wr),
    .mem_wr_en_o (mem_wr),
    .mem_rd_en_o (mem_rd),
    .op1_sel_o   (op1_sel),
    .op2_sel_o   (op2_sel)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_o   (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic        ill;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    //          instr          imm           rd  rw mr mw op1 op2 ill
    vecs[0]  = '{32'hFFF00293, 32'hFFFFFFFF, 5,  1, 0, 0, 0, 1, 0}; // ADDI x5,x0,-1
    vecs[1]  = '{32'h00218233, 32'h00000000, 4,  1, 0, 0, 0, 0, 0}; // ADD x4,x3,x2
    vecs[2]  = '{32'h0000A183, 32'h00000000, 3,  1, 1, 0, 0, 1, 0}; // LW x3,0(x1)
    vecs[3]  = '{32'h0020A423, 32'h00000008, 8,  0, 0, 1, 0, 1, 0}; // SW x2,8(x1)
    vecs[4]  = '{32'hFE208EE3, 32'hFFFFFFFC, 29, 0, 0, 0, 0, 0, 0}; // BEQ x1,x2,-4
    vecs[5]  = '{32'h123453B7, 32'h12345000, 7,  1, 0, 0, 2, 1, 0}; // LUI x7
    vecs[6]  = '{32'h80000417, 32'h80000000, 8,  1, 0, 0, 1, 1, 0}; // AUIPC x8
    vecs[7]  = '{32'h001000EF, 32'h00000800, 1,  1, 0, 0, 1, 2, 0}; // JAL x1,+2048
    vecs[8]  = '{32'h00008067, 32'h00000000, 0,  0, 0, 0, 1, 2, 0}; // JALR x0,0(x1)
    vecs[9]  = '{32'h4032D313, 32'h00000403, 6,  1, 0, 0, 0, 1, 0}; // SRAI x6,x5,3
    vecs[10] = '{32'h000002FF, 32'h00000000, 5,  0, 0, 0, 0, 0, 1}; // opcode 0x7F
`ifdef DECODE_ILLEGAL_TRAP_EN
    vecs[11] = '{32'h02218233, 32'h00000000, 4,  0, 0, 0, 0, 0, 1}; // OP func7=0x01
`else
    vecs[11] = '{32'h02218233, 32'h00000000, 4,  1, 0, 0, 0, 0, 0};
`endif

    rst_n = 1'b0; in_valid = 1'b0; instr = NOP; pc = 32'h0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset imm", imm_q, 32'd0);
    chk("reset rd", {27'b0, rd_q}, 32'd0);
    chk("reset reg_wr", {31'b0, reg_wr}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("reset illegal", {31'b0, illegal}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr; pc = 32'h1000 + 32'(i * 4);
      #1;
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      step();
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d pc", i), pc_q, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d opcode", i), {25'b0, opcode_q}, {25'b0, vecs[i].instr[6:0]});
      chk($sformatf("v%0d imm", i), imm_q, vecs[i].imm);
      chk($sformatf("v%0d rd", i), {27'b0, rd_q}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d reg_wr", i), {31'b0, reg_wr}, {31'b0, vecs[i].rw});
      chk($sformatf("v%0d mem_rd", i), {31'b0, mem_rd}, {31'b0, vecs[i].mr});
      chk($sformatf("v%0d mem_wr", i), {31'b0, mem_wr}, {31'b0, vecs[i].mw});
      chk($sformatf("v%0d op1", i), {29'b0, op1_sel}, {29'b0, vecs[i].op1});
      chk($sformatf("v%0d op2", i), {29'b0, op2_sel}, {29'b0, vecs[i].op2});
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk($sformatf("v%0d illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
`endif
      in_valid = 1'b0; instr = NOP;
      step(); step();
    end

    // Back-to-back load-use: exactly one bubble.
    in_valid = 1'b1; instr = 32'h0000A183;
    step();
    chk("lu cyc1 out_valid", {31'b0, out_valid}, 32'd1);
    instr = 32'h00218233; #1;
    chk("lu cyc1 in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("lu cyc2 out_valid", {31'b0, out_valid}, 32'd0);
    chk("lu cyc2 in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("lu cyc3 out_valid", {31'b0, out_valid}, 32'd1);
    chk("lu cyc3 rd", {27'b0, rd_q}, 32'd4);
    in_valid = 1'b0; instr = NOP;
    step(); step();

    // No bubble for x0 load or unrelated source.
    in_valid = 1'b1; instr = 32'h00008003;
    step();
    instr = 32'h00200233; #1;
    chk("x0 in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("x0 out_valid", {31'b0, out_valid}, 32'd1);
    chk("x0 rd", {27'b0, rd_q}, 32'd4);
    instr = 32'h0000A183;
    step();
    instr = 32'h00238233; #1;
    chk("x7 in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("x7 out_valid", {31'b0, out_valid}, 32'd1);
    chk("x7 rs1", {27'b0, rs1_q}, 32'd7);
    in_valid = 1'b0; instr = NOP;
    step(); step();

    // Load shadow blocks a dependent arriving after a fetch gap.
    in_valid = 1'b1; instr = 32'h0000A183;
    step();
    in_valid = 1'b0; instr = NOP;
    step();
    in_valid = 1'b1; instr = 32'h00218233; #1;
    chk("shadow in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("shadow out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0; instr = NOP;
    step(); step();

    // Flush at the load handoff clears the shadow.
    in_valid = 1'b1; instr = 32'h0000A183;
    step();
    in_valid = 1'b0; instr = NOP; flush = 1'b1;
    step();
    flush = 1'b0; instr = 32'h00218233; #1;
    chk("flush shadow in_ready", {31'b0, in_ready}, 32'd1);
    instr = NOP;
    step(); step();

    // JAL held for 3 cycles under backpressure, then handoff with reload.
    in_valid = 1'b1; instr = 32'h001000EF;
    step();
    out_ready = 1'b0; instr = 32'h00100493;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d imm", k), imm_q, 32'h800);
      chk($sformatf("hold%0d op1", k), {29'b0, op1_sel}, 32'd1);
      chk($sformatf("hold%0d op2", k), {29'b0, op2_sel}, 32'd2);
      step();
    end
    out_ready = 1'b1; #1;
    chk("reload in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("reload out_valid", {31'b0, out_valid}, 32'd1);
    chk("reload rd", {27'b0, rd_q}, 32'd9);
    chk("reload imm", imm_q, 32'd1);
    in_valid = 1'b0; instr = NOP;
    step();

    // Flush during an accept drops the instruction.
    in_valid = 1'b1; instr = 32'h00100513; flush = 1'b1; #1;
    chk("flush acc in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("flush acc out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0; flush = 1'b0; instr = NOP;
    step();
    chk("flush acc never", {31'b0, out_valid}, 32'd0);

    // Flush of a held entry.
    in_valid = 1'b1; instr = 32'h00100593;
    step();
    chk("held out_valid", {31'b0, out_valid}, 32'd1);
    chk("held rd", {27'b0, rd_q}, 32'd11);
    in_valid = 1'b0; instr = NOP; out_ready = 1'b0; flush = 1'b1;
    step();
    chk("held flushed", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    step();

    // Asynchronous reset in the middle of a stall.
    in_valid = 1'b1; instr = 32'h001000EF;
    step();
    out_ready = 1'b0; instr = 32'h00100493; #1;
    chk("stall in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0; #1;
    chk("rst stall out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst stall in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst stall imm", imm_q, 32'd0);
    step();
    rst_n = 1'b1; in_valid = 1'b0; instr = NOP;
    step();
    chk("post rst out_valid", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
